// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one uart_tx serializer among
//               NUM_REQ requesters. Captures the winner's byte, pulses
//               tx_start, waits for tx_done, then enforces an optional
//               inter-frame gap before arbitrating again.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1                   system clock, rising edge
//   rst_n        in   1                   synchronous active-low reset
//   req          in   NUM_REQ             req[i]=1: requester i has a byte
//   req_data     in   NUM_REQ*DATA_WIDTH  byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          out  NUM_REQ             1-cycle pulse: byte i captured
//   done         out  NUM_REQ             1-cycle pulse: frame of i sent
//   tx_start     out  1                   uart_tx start pulse
//   tx_data      out  DATA_WIDTH          uart_tx payload, stable until done
//   tx_done      in   1                   uart_tx frame complete
//   busy         out  1                   arbiter not idle
//   grant_id     out  $clog2(NUM_REQ)     current / last granted requester
//   timeout_err  out  1                   sticky WAIT watchdog flag
// Configuration
//   UART_TX_ARB_TIMEOUT_EN : when defined, WAIT is bounded by TIMEOUT_CYCLES
//                            and timeout_err is live; otherwise tied 0.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              done,
    output logic                            tx_start,
    output logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            tx_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            timeout_err
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    // A zero gap still gets a 1-bit counter so the declarations stay legal.
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_ID_W:0]    c_NUM_REQ   = (c_ID_W + 1)'(NUM_REQ);
    localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(GAP_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_ID_W-1:0]  c_ID_ONE    = c_ID_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_ID_W-1:0]      r_ptr;
    logic [c_ID_W-1:0]      w_ptr_nxt;
    logic [c_ID_W-1:0]      r_grant;
    logic [c_ID_W-1:0]      w_grant_nxt;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [NUM_REQ-1:0]     r_done;
    logic [NUM_REQ-1:0]     w_done_nxt;
    logic [c_GAP_W-1:0]     r_gap_cnt;
    logic [c_GAP_W-1:0]     w_gap_cnt_nxt;

    logic [c_ID_W-1:0]      w_winner;
    logic                   w_any_req;
    logic [c_ID_W:0]        w_sum;
    logic                   w_timeout;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan ptr, ptr+1, ... modulo NUM_REQ. The loop runs
    // from the farthest offset down so the nearest pending requester is the
    // last (and therefore winning) assignment.
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner  = '0;
        w_any_req = 1'b0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W + 1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (req[w_sum[c_ID_W-1:0]]) begin
                w_winner  = w_sum[c_ID_W-1:0];
                w_any_req = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_data_nxt    = r_data;
        w_done_nxt    = '0;
        w_gap_cnt_nxt = r_gap_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = w_winner;
                    w_data_nxt  = req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
                    w_state_nxt = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                // Advancing past the granted requester gives fairness.
                w_ptr_nxt   = (r_grant == c_LAST_ID) ? '0 : (r_grant + c_ID_ONE);
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                // tx_done wins over a watchdog expiry in the same cycle.
                if (tx_done || w_timeout) begin
                    if (tx_done) begin
                        w_done_nxt[r_grant] = 1'b1;
                    end
                    if (GAP_CYCLES > 0) begin
                        w_gap_cnt_nxt = c_GAP_ONE;
                        w_state_nxt   = ST_GAP;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                // Counter holds the 1-based index of the current gap cycle.
                if (r_gap_cnt >= c_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_GAP_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_data    <= '0;
            r_done    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------------
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int               c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_to_err;

    // r_to_cnt holds the number of WAIT cycles already spent without tx_done;
    // it is cleared every cycle outside WAIT so each frame starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT) begin
                r_to_cnt <= '0;
            end else if (!tx_done) begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end
            if (w_timeout) begin
                r_to_err <= 1'b1;
            end
        end
    end

    assign w_timeout   = (r_state == ST_WAIT) && !tx_done && (r_to_cnt == c_TO_LAST);
    assign timeout_err = r_to_err;
`else
    assign w_timeout   = 1'b0;
    // Always 0; written against the parameter so it stays referenced.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        ack = '0;
        if (r_state == ST_LAUNCH) begin
            ack[r_grant] = 1'b1;
        end
    end

    assign tx_start = (r_state == ST_LAUNCH);
    assign tx_data  = r_data;
    assign done     = r_done;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. A timestamp-based
//               transaction model predicts every output each cycle; directed
//               sequences pin the model with hand-computed literals; a
//               randomized phase exercises requesters, resets and a
//               behavioural uart_tx responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 5;
    localparam int TO  = 100;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            tx_done  = 1'b0;

    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: tracks transactions by edge timestamps.
    //   m_launch  : edge at which the winner was sampled (launch visible after)
    //   m_free_at : first edge at which the arbiter may sample req again
    // ------------------------------------------------------------------------
    bit            m_valid = 1'b0;
    bit            m_in_frame;
    int            m_launch;
    int            m_free_at;
    int            m_ptr;
    int            m_grant;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit            e_launch;
    bit            e_done;
    bit            m_found;
    int            m_idx;
    int            x_edge;
    logic [N-1:0]  m_oh;

    always @(posedge clk) begin
        x_edge = cyc;
        if (!rst_n) begin
            m_valid    = 1'b1;
            m_in_frame = 1'b0;
            m_free_at  = x_edge + 1;
            m_ptr      = 0;
            m_grant    = 0;
            m_data     = '0;
            m_err      = 1'b0;
            e_launch   = 1'b0;
            e_done     = 1'b0;
        end else if (m_valid) begin
            e_launch = 1'b0;
            e_done   = 1'b0;
            if (m_in_frame) begin
                // tx_done seen in the launch cycle itself does not count.
                if (x_edge >= m_launch + 2 && tx_done) begin
                    e_done     = 1'b1;
                    m_in_frame = 1'b0;
                    m_free_at  = x_edge + 1 + GAP;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (x_edge - m_launch - 1 == TO) begin
                    m_err      = 1'b1;
                    m_in_frame = 1'b0;
                    m_free_at  = x_edge + 1 + GAP;
                end
`endif
            end else if (x_edge >= m_free_at && req != '0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_idx = (m_ptr + k) % N;
                    if (!m_found && req[m_idx]) begin
                        m_found = 1'b1;
                        m_grant = m_idx;
                    end
                end
                m_data     = req_data[m_grant*DW +: DW];
                m_in_frame = 1'b1;
                m_launch   = x_edge;
                e_launch   = 1'b1;
                m_ptr      = (m_grant + 1) % N;
            end
        end
        cyc = cyc + 1;
        #1;
        if (m_valid) begin
            m_oh          = '0;
            m_oh[m_grant] = 1'b1;
            chk("tx_start",    tx_start,    e_launch);
            chk("ack",         ack,         e_launch ? m_oh : '0);
            chk("done",        done,        e_done ? m_oh : '0);
            chk("busy",        busy,        (m_in_frame || (x_edge < m_free_at - 1)));
            chk("grant_id",    grant_id,    m_grant);
            chk("tx_data",     tx_data,     m_data);
            chk("timeout_err", timeout_err, m_err);
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural uart_tx: answers tx_start with a tx_done pulse later.
    // ------------------------------------------------------------------------
    int uart_cnt       = 0;
    int uart_delay     = 4;
    bit uart_mute      = 1'b0;
    bit uart_rand      = 1'b0;
    bit uart_rand_mute = 1'b0;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) tx_done = 1'b1;
        end
        if (tx_start === 1'b1) begin
            // Spurious completion in the launch cycle must be ignored.
            if (uart_rand && $urandom_range(0, 3) == 0) tx_done = 1'b1;
            if (!uart_mute && !(uart_rand_mute && $urandom_range(0, 7) == 0))
                uart_cnt = uart_rand ? int'($urandom_range(1, 10)) : uart_delay;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "simulation timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int t_launch;
    int last_done;
    int n_grant;
    int grants [5];
    int gap1;
    bit seen;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---- 1: single request ------------------------------------------------
        uart_delay = 4;
        @(negedge clk);
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'hA5;
        @(posedge clk); #1;
        t_launch = cyc;
        chk("t1_ack",      ack,      4'b0100);
        chk("t1_tx_start", tx_start, 1'b1);
        chk("t1_tx_data",  tx_data,  8'hA5);
        chk("t1_grant",    grant_id, 2);
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done != '0) break;
        end
        chk("t1_done",         done,           4'b0100);
        chk("t1_done_latency", cyc - t_launch, 5);

        // ---- 2/3: all requesting, rotation and gap ---------------------------
        do_reset();
        uart_delay = 2;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
        req       = 4'hF;
        n_grant   = 0;
        last_done = 0;
        gap1      = -1;
        for (int i = 0; i < 5; i++) grants[i] = 99;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done != '0) last_done = cyc;
            if (tx_start === 1'b1) begin
                grants[n_grant] = int'(grant_id);
                if (n_grant == 1) gap1 = cyc - last_done - 1;
                n_grant++;
                if (n_grant == 5) break;
            end
        end
        for (int i = 0; i < 5; i++) chk("t2_grant_order", grants[i], exp_order[i]);
        chk("t3_gap_cycles", gap1, 5);
        @(negedge clk);
        req = '0;
        repeat (30) @(negedge clk);

        // ---- 4: reset during WAIT, late tx_done ignored ----------------------
        do_reset();
        uart_delay = 8;
        req = 4'b0001;
        req_data[0 +: DW] = 8'h3C;
        @(posedge clk); #1;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        chk("t4_busy_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t4_reset_outputs", {ack, done, tx_start, tx_data, busy, grant_id, timeout_err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done != '0 || busy) seen = 1'b1;
        end
        chk("t4_quiet_after_reset", seen, 1'b0);

        // ---- 5: withdrawn request never acknowledged -------------------------
        do_reset();
        uart_delay = 3;
        req = 4'b0001;
        req_data[0 +: DW] = 8'h01;
        @(posedge clk); #1;
        @(negedge clk);
        req_data[1*DW +: DW] = 8'h11;
        req_data[3*DW +: DW] = 8'h33;
        req = 4'b1010;
        @(negedge clk);
        req = 4'b1000;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) break;
        end
        chk("t5_ack",     ack,     4'b1000);
        chk("t5_tx_data", tx_data, 8'h33);
        @(negedge clk);
        req = '0;
        repeat (25) @(negedge clk);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ---- 6: watchdog expiry ----------------------------------------------
        do_reset();
        uart_mute = 1'b1;
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'h5A;
        @(posedge clk); #1;
        t_launch = cyc;
        @(negedge clk);
        req_data[1*DW +: DW] = 8'h22;
        req = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done != '0) seen = 1'b1;
            if (timeout_err === 1'b1) break;
        end
        chk("t6_timeout_latency", cyc - t_launch, 101);
        chk("t6_no_done",         seen,           1'b0);
        uart_mute = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) break;
        end
        chk("t6_next_ack", ack, 4'b0010);
        @(negedge clk);
        req = '0;
        repeat (25) @(negedge clk);
        uart_rand_mute = 1'b1;
`endif

        // ---- randomized phase -------------------------------------------------
        do_reset();
        uart_rand = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 2) == 0) req_data[i*DW +: DW] = DW'($urandom);
                        else req[i] = 1'b0;
                    end else if ($urandom_range(0, 49) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        repeat (200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
